// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead add/subtract unit with valid/ready handshakes.
// Stage 1 forms bit and nibble propagate/generate; stage 2 resolves carries, sum and flags.
module pipelined_cla_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             P_out,
  output logic             G_out
);

  localparam int NNIB = WIDTH / 4;
  localparam int NSLC = WIDTH / 16;

  // Four-bit lookahead: returns carries c0..c4 from group/bit propagate and generate.
  function automatic logic [4:0] cla4(input logic [3:0] pp, input logic [3:0] gg,
                                      input logic c0);
    logic [4:0] c;
    c[0] = c0;
    c[1] = gg[0] | (pp[0] & c0);
    c[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c0);
    c[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & c0);
    c[4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0])
         | (pp[3] & pp[2] & pp[1] & pp[0] & c0);
    return c;
  endfunction

  // Handshake
  logic w_s1_adv, w_s2_adv;
  logic r_s1_valid, r_s2_valid;

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  // Stage 1: operand conditioning and propagate/generate
  logic [WIDTH-1:0] w_b_eff, w_p, w_g;
  logic [NNIB-1:0]  w_grp_p, w_grp_g;
  logic             w_cin_eff;

  assign w_b_eff   = sub ? ~b : b;
  assign w_cin_eff = sub ? 1'b1 : c_in;
  assign w_p       = a ^ w_b_eff;
  assign w_g       = a & w_b_eff;

  always_comb begin
    logic [4:0] w_nc;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    w_grp_p = '0;
    w_grp_g = '0;
    w_nc    = '0;
    for (int k = 0; k < NNIB; k++) begin
      w_nc       = cla4(w_p[4*k +: 4], w_g[4*k +: 4], 1'b0);
      w_grp_p[k] = &w_p[4*k +: 4];
      w_grp_g[k] = w_nc[4];
    end
  end

  logic [WIDTH-1:0] r_p, r_g;
  logic [NNIB-1:0]  r_grp_p, r_grp_g;
  logic             r_cin, r_a_msb, r_b_msb;

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_p        <= '0;
      r_g        <= '0;
      r_grp_p    <= '0;
      r_grp_g    <= '0;
      r_cin      <= 1'b0;
      r_a_msb    <= 1'b0;
      r_b_msb    <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_p     <= w_p;
        r_g     <= w_g;
        r_grp_p <= w_grp_p;
        r_grp_g <= w_grp_g;
        r_cin   <= w_cin_eff;
        r_a_msb <= a[WIDTH-1];
        r_b_msb <= w_b_eff[WIDTH-1];
      end
    end
  end

  // Stage 2: second-level lookahead per 16-bit slice, slices chained by their carry-out
  logic [WIDTH-1:0] w_carry, w_sum;
  logic             w_c_final, w_g_word;

  always_comb begin
    logic [4:0] w_nib, w_bitc, w_gnib;
    logic       w_slc_c, w_gen_c;
    w_carry = '0;
    w_nib   = '0;
    w_bitc  = '0;
    w_gnib  = '0;
    w_slc_c = r_cin;
    w_gen_c = 1'b0;
    for (int j = 0; j < NSLC; j++) begin
      w_nib = cla4(r_grp_p[4*j +: 4], r_grp_g[4*j +: 4], w_slc_c);
      for (int k = 0; k < 4; k++) begin
        w_bitc = cla4(r_p[16*j + 4*k +: 4], r_g[16*j + 4*k +: 4], w_nib[k]);
        w_carry[16*j + 4*k +: 4] = w_bitc[3:0];
      end
      w_slc_c = w_nib[4];
      w_gnib  = cla4(r_grp_p[4*j +: 4], r_grp_g[4*j +: 4], w_gen_c);
      w_gen_c = w_gnib[4];
    end
    w_c_final = w_slc_c;
    w_g_word  = w_gen_c;
  end

  assign w_sum = r_p ^ w_carry;

  logic [WIDTH-1:0] r_sum;
  logic             r_c_out, r_overflow, r_p_out, r_g_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_sum      <= '0;
      r_c_out    <= 1'b0;
      r_overflow <= 1'b0;
      r_p_out    <= 1'b0;
      r_g_out    <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sum      <= w_sum;
        r_c_out    <= w_c_final;
        r_overflow <= (r_a_msb == r_b_msb) && (w_sum[WIDTH-1] != r_a_msb);
        r_p_out    <= &r_p;
        r_g_out    <= w_g_word;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign sum       = r_sum;
  assign c_out     = r_c_out;
  assign overflow  = r_overflow;
  assign P_out     = r_p_out;
  assign G_out     = r_g_out;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder: hand-computed vector table, handshake
// sequences (streaming, stall, async reset) and a randomized scoreboard run.
module tb_pipelined_cla_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic         c_in = 1'b0, sub = 1'b0;
  logic         out_valid, out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         c_out, overflow, P_out, G_out;

  pipelined_cla_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .overflow(overflow), .P_out(P_out), .G_out(G_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         c, ovf, p, g;
  } res_t;

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin, sub;
    res_t         exp;
  } vec_t;

  int   checks = 0, failures = 0;
  res_t sb[$];
  int   cyc = 0, out_cnt = 0, first_out = 0, last_out = 0;
  logic last_in_ready = 1'b0, last_accept = 1'b0;
  logic hold_pending = 1'b0;
  res_t held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic res_t got();
    return {sum, c_out, overflow, P_out, G_out};
  endfunction

  // Behavioural reference: plain integer arithmetic, signed range test for overflow.
  function automatic res_t ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                     input logic rcin, input logic rsub);
    res_t         r;
    logic [W-1:0] bb;
    logic [W:0]   full, gen;
    int           s;
    bb    = rsub ? ~rb : rb;
    full  = {1'b0, ra} + {1'b0, bb} + ((rsub || rcin) ? (W+1)'(1) : (W+1)'(0));
    gen   = {1'b0, ra} + {1'b0, bb};
    s     = rsub ? (int'($signed(ra)) - int'($signed(rb)))
                 : (int'($signed(ra)) + int'($signed(rb)) + int'(rcin));
    r.sum = full[W-1:0];
    r.c   = full[W];
    r.ovf = (s > 32767) || (s < -32768);
    r.p   = &(ra ^ bb);
    r.g   = gen[W];
    return r;
  endfunction

  // One clock cycle of handshake-level stimulus with scoreboard and hold-stability checks.
  task automatic step(input logic v, input logic ordy, input logic [W-1:0] sa,
                      input logic [W-1:0] sb_b, input logic scin, input logic ssub);
    res_t exp_r;
    @(negedge clk);
    cyc++;
    if (hold_pending) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_stable", got(), held);
    end
    in_valid = v; a = sa; b = sb_b; c_in = scin; sub = ssub; out_ready = ordy;
    #1;
    last_in_ready = in_ready;
    last_accept   = in_valid && in_ready;
    if (last_accept) sb.push_back(ref_model(sa, sb_b, scin, ssub));
    if (out_valid && out_ready) begin
      check("sb_nonempty", sb.size() > 0, 1'b1);
      if (sb.size() > 0) begin
        exp_r = sb.pop_front();
        check("stream_result", got(), exp_r);
      end
      out_cnt++;
      if (out_cnt == 1) first_out = cyc;
      last_out = cyc;
    end
    hold_pending = out_valid && !out_ready;
    held         = got();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() > 0) && (n < budget)) begin
      step(1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
      n++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  vec_t tbl[10];

  initial begin
    int   n, acc, c;
    res_t r0;

    //            a         b          cin   sub      sum       c     ovf   p     g
    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b1}};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, '{16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[3] = '{16'hAAAA, 16'h5555, 1'b1, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}};
    tbl[4] = '{16'h0000, 16'h0000, 1'b0, 1'b0, '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[5] = '{16'h0000, 16'h0000, 1'b0, 1'b1, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}};
    tbl[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1}};
    tbl[7] = '{16'h1234, 16'h4321, 1'b1, 1'b0, '{16'h5556, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, '{16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1}};
    tbl[9] = '{16'h0003, 16'h0003, 1'b0, 1'b1, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_outputs", got(), '0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b1);

    // Table-driven single operations with latency check
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = tbl[i].a; b = tbl[i].b; c_in = tbl[i].cin; sub = tbl[i].sub;
      #1;
      check($sformatf("tbl%0d_in_ready", i), in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 8) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("tbl%0d_latency", i), n, 2);
      check($sformatf("tbl%0d_result", i), got(), tbl[i].exp);
    end
    @(negedge clk);

    // Eight back-to-back operations, one result per cycle, in order
    out_cnt = 0;
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, 16'h1111 * i[15:0], 16'h0F0F + i[15:0], i[0], i[1]);
    drain(10);
    check("b2b_count", out_cnt, 8);
    check("b2b_span", last_out - first_out, 7);

    // Stall from empty: two accepts then in_ready drops; outputs hold; nothing lost
    out_cnt = 0;
    acc = 0;
    c = 0;
    while (acc < 8 && c < 40) begin
      step(1'b1, (c >= 3), 16'hC000 + acc[15:0], 16'h4000 - acc[15:0], 1'b1, acc[0]);
      if (c < 3) check($sformatf("stall_in_ready_c%0d", c), last_in_ready, (c < 2));
      if (last_accept) acc++;
      c++;
    end
    drain(10);
    check("stall_count", out_cnt, 8);

    // Asynchronous reset with two ops in flight
    step(1'b1, 1'b0, 16'h0101, 16'h0202, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0303, 16'h0404, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_sum", sum, '0);
    sb.delete();
    hold_pending = 1'b0;
    @(negedge clk);
    check("rst_no_pulse", out_valid, 1'b0);
    rst_n = 1'b1;
    out_cnt = 0;
    step(1'b1, 1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    r0 = ref_model(16'h00FF, 16'h0001, 1'b0, 1'b0);
    check("post_rst_model", r0.sum, 16'h0100);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
    check("post_rst_count", out_cnt, 1);

    // Randomized traffic against the reference model
    acc = 0;
    c = 0;
    while (acc < 10000 && c < 60000) begin
      step(($urandom_range(3) != 0), ($urandom_range(3) != 0), W'($urandom),
           W'($urandom), 1'($urandom), 1'($urandom));
      if (last_accept) acc++;
      c++;
    end
    check("rand_accepted", acc, 10000);
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
